// File: rtl/if_prefetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect
// and the decode-side instruction handoff.
interface if_prefetch_queue_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            mem_en;
  logic            mem_req_valid_op;
  logic            mem_req_ready_ip;
  logic [XLEN-1:0] mem_req_addr_op;
  logic            mem_rsp_valid_ip;
  logic [XLEN-1:0] mem_rsp_data_ip;
  logic            redirect_valid_ip;
  logic [XLEN-1:0] redirect_pc_ip;
  logic            stall_ip;
  logic            instr_valid_op;
  logic [XLEN-1:0] instr_data_op;
  logic [XLEN-1:0] instr_pc_addr_op;

  modport master (
    input  mem_en,
    output mem_req_valid_op,
    input  mem_req_ready_ip,
    output mem_req_addr_op,
    input  mem_rsp_valid_ip,
    input  mem_rsp_data_ip,
    input  redirect_valid_ip,
    input  redirect_pc_ip,
    input  stall_ip,
    output instr_valid_op,
    output instr_data_op,
    output instr_pc_addr_op
  );

  modport slave (
    output mem_en,
    input  mem_req_valid_op,
    output mem_req_ready_ip,
    input  mem_req_addr_op,
    output mem_rsp_valid_ip,
    output mem_rsp_data_ip,
    output redirect_valid_ip,
    output redirect_pc_ip,
    output stall_ip,
    input  instr_valid_op,
    input  instr_data_op,
    input  instr_pc_addr_op
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction fetch unit with DEPTH-entry prefetch queue, credit-limited
// in-order memory requests and redirect squashing. IF_PREFETCH_BYPASS_EN adds a response-to-decode bypass.
module if_prefetch_queue #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  if_prefetch_queue_if.master  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] MAXO_W  = PW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]   wr_ptr, rd_ptr, occ;
  logic [PW-1:0]   outstanding, out_nxt;
  logic [PW-1:0]   drop_cnt, drop_cnt_nxt;
  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] tag_pc [MAX_OUTSTANDING];
  logic [TW-1:0]   tag_wr, tag_rd;

  logic            req_valid, req_fire, rsp_fire, rsp_keep, redirect;
  logic            q_empty, push, pop_q, credit;
  logic [PW:0]     inflight;
  logic [XLEN-1:0] rsp_pc, head_pc, head_data;
  logic            out_valid;
  logic [XLEN-1:0] out_pc, out_data;

  assign redirect = bus.redirect_valid_ip;
  assign rsp_fire = bus.mem_rsp_valid_ip;
  assign req_fire = req_valid && bus.mem_req_ready_ip;

  assign occ      = wr_ptr - rd_ptr;
  assign q_empty  = (wr_ptr == rd_ptr);
  assign inflight = {1'b0, occ} + {1'b0, outstanding};
  // Reserving a slot per outstanding request means a response never needs back-pressure.
  assign credit   = (inflight < DEPTH_W) && (outstanding < MAXO_W);
  assign out_nxt  = outstanding + PW'(req_fire) - PW'(rsp_fire);

  assign rsp_pc    = tag_pc[tag_rd];
  assign head_pc   = q_pc[rd_ptr[AW-1:0]];
  assign head_data = q_data[rd_ptr[AW-1:0]];

  // Responses belonging to squashed fetches are dropped, including one landing on the redirect cycle.
  assign rsp_keep = rsp_fire && (state != S_DRAIN) && !redirect;
  assign pop_q    = !q_empty && !bus.stall_ip;

`ifdef IF_PREFETCH_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_keep && q_empty;
  assign push      = rsp_keep && !(bypass && !bus.stall_ip);
  assign out_valid = !q_empty || bypass;
  assign out_pc    = q_empty ? rsp_pc : head_pc;
  assign out_data  = q_empty ? bus.mem_rsp_data_ip : head_data;
`else
  assign push      = rsp_keep;
  assign out_valid = !q_empty;
  assign out_pc    = head_pc;
  assign out_data  = head_data;
`endif

  assign bus.instr_valid_op   = out_valid;
  assign bus.instr_pc_addr_op = out_valid ? out_pc : '0;
  assign bus.instr_data_op    = out_valid ? out_data : '0;
  assign bus.mem_req_valid_op = req_valid;
  assign bus.mem_req_addr_op  = fetch_pc;

  always_comb begin
    state_nxt    = state;
    req_valid    = 1'b0;
    drop_cnt_nxt = drop_cnt;
    unique case (state)
      S_IDLE: begin
        if (bus.mem_en) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        req_valid = bus.mem_en && credit;
        if (!bus.mem_en && (outstanding == '0)) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        drop_cnt_nxt = drop_cnt - PW'(rsp_fire);
        if (drop_cnt_nxt == '0) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (redirect) begin
      drop_cnt_nxt = out_nxt;
      state_nxt    = (out_nxt != '0) ? S_DRAIN : S_FETCH;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      outstanding <= out_nxt;
      drop_cnt    <= drop_cnt_nxt;
      if (redirect)      fetch_pc <= {bus.redirect_pc_ip[XLEN-1:2], 2'b00};
      else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PW'(1);
        if (pop_q) rd_ptr <= rd_ptr + PW'(1);
      end
      // Tag FIFO tracks every in-flight request, squashed or not, so it stays aligned with responses.
      if (req_fire) tag_wr <= (tag_wr == TAG_LAST) ? '0 : tag_wr + TW'(1);
      if (rsp_fire) tag_rd <= (tag_rd == TAG_LAST) ? '0 : tag_rd + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (req_fire) tag_pc[tag_wr] <= fetch_pc;
    if (push && !redirect) begin
      q_pc[wr_ptr[AW-1:0]]   <= rsp_pc;
      q_data[wr_ptr[AW-1:0]] <= bus.mem_rsp_data_ip;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue: transaction-level memory and decode
// model tagged by redirect epoch.
module tb_if_prefetch_queue;
  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     DEPTH    = 4;
  localparam int unsigned     MAXO     = 2;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam int FIRST_LAT = 2;
`else
  localparam int FIRST_LAT = 3;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  if_prefetch_queue_if #(.XLEN(XLEN)) bus ();

  if_prefetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned epoch;
    int unsigned due;
  } pend_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  pend_t       pend[$];
  ent_t        q[$];
  logic [31:0] fpc;
  int unsigned cur_epoch, cyc, last_due;
  logic        en, en_prev;
  int          first_req, first_instr;
  int unsigned p_stall, p_ready, k_min, k_max, p_redir, p_enoff;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_knobs(input int unsigned st, input int unsigned rd, input int unsigned kmin,
                           input int unsigned kmax, input int unsigned rdr, input int unsigned eoff);
    p_stall = st; p_ready = rd; k_min = kmin; k_max = kmax; p_redir = rdr; p_enoff = eoff;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_valid"}, 32'(bus.mem_req_valid_op), 32'd0);
    check_eq({pfx, "_req_addr"},  bus.mem_req_addr_op, RESET_PC);
    check_eq({pfx, "_instr_valid"}, 32'(bus.instr_valid_op), 32'd0);
    check_eq({pfx, "_instr_data"}, bus.instr_data_op, 32'd0);
    check_eq({pfx, "_instr_pc"},   bus.instr_pc_addr_op, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.mem_en = 1'b0; bus.mem_req_ready_ip = 1'b0; bus.mem_rsp_valid_ip = 1'b0;
    bus.mem_rsp_data_ip = '0; bus.redirect_valid_ip = 1'b0; bus.redirect_pc_ip = '0;
    bus.stall_ip = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    pend.delete(); q.delete();
    fpc = RESET_PC; en_prev = 1'b0; last_due = 0; cyc = 0;
    first_req = -1; first_instr = -1;
    reset = 1'b1;
  endtask

  task automatic do_cycle();
    int unsigned old_cnt, due;
    logic        acc, rsp_v, redir, kept, visible, credit;
    logic [31:0] rpc;
    ent_t        h;
    pend_t       e;
    en    = ($urandom_range(99) >= p_enoff);
    redir = ($urandom_range(99) < p_redir);
    case ($urandom_range(3))
      0:       rpc = 32'h203;
      1:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      default: rpc = $urandom;
    endcase
    rsp_v = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.mem_en            = en;
    bus.stall_ip          = ($urandom_range(99) < p_stall);
    bus.mem_req_ready_ip  = ($urandom_range(99) < p_ready);
    bus.redirect_valid_ip = redir;
    bus.redirect_pc_ip    = rpc;
    bus.mem_rsp_valid_ip  = rsp_v;
    bus.mem_rsp_data_ip   = rsp_v ? pend[0].data : $urandom;

    @(negedge clock);
    old_cnt = 0;
    foreach (pend[i]) if (pend[i].epoch != cur_epoch) old_cnt++;
    credit = (q.size() + pend.size() < DEPTH) && (pend.size() < MAXO);
    if (!en) check_eq("req_when_disabled", 32'(bus.mem_req_valid_op), 32'd0);
    else if (en_prev && old_cnt == 0) check_eq("req_valid", 32'(bus.mem_req_valid_op), 32'(credit));
    if (bus.mem_req_valid_op) check_eq("req_addr", bus.mem_req_addr_op, fpc);

    kept    = rsp_v && (pend[0].epoch == cur_epoch) && !redir;
    visible = (q.size() > 0);
`ifdef IF_PREFETCH_BYPASS_EN
    visible = visible || kept;
`endif
    check_eq("instr_valid", 32'(bus.instr_valid_op), 32'(visible));
    if (visible) begin
      if (q.size() > 0) h = q[0];
      else begin h.pc = pend[0].addr; h.data = pend[0].data; end
      check_eq("instr_pc", bus.instr_pc_addr_op, h.pc);
      check_eq("instr_data", bus.instr_data_op, h.data);
    end
    if (first_req < 0 && bus.mem_req_valid_op) first_req = int'(cyc);
    if (first_instr < 0 && bus.instr_valid_op) first_instr = int'(cyc);

    acc = bus.mem_req_valid_op && bus.mem_req_ready_ip;
    if (rsp_v) begin
      e = pend.pop_front();
      if (kept) begin h.pc = e.addr; h.data = e.data; q.push_back(h); end
    end
    if (visible && !bus.stall_ip && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      due = cyc + $urandom_range(k_max, k_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr = fpc; e.data = $urandom; e.epoch = cur_epoch; e.due = due;
      pend.push_back(e);
    end
    if (redir) begin
      fpc = {rpc[31:2], 2'b00};
      q.delete();
      cur_epoch++;
    end else if (acc) begin
      fpc = fpc + 32'd4;
    end
    en_prev = en;

    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    cur_epoch = 0;
    do_reset();

    // Streaming, single-cycle latency: first request and first head timing
    set_knobs(0, 100, 1, 1, 0, 0);
    repeat (20) do_cycle();
    check_eq("first_req_cycle", 32'(first_req), 32'd1);
    check_eq("first_instr_cycle", 32'(first_instr), 32'(FIRST_LAT));

    // Decode stalled: queue fills to DEPTH and requests stop
    set_knobs(100, 100, 1, 1, 0, 0);
    repeat (12) do_cycle();
    check_eq("full_req_stopped", 32'(bus.mem_req_valid_op), 32'd0);
    check_eq("full_head_valid", 32'(bus.instr_valid_op), 32'd1);
    set_knobs(0, 100, 1, 1, 0, 0);
    repeat (12) do_cycle();

    // Long latency against the outstanding limit
    set_knobs(0, 100, 3, 3, 0, 0);
    repeat (40) do_cycle();

    // Fully random traffic with redirects and enable drops
    set_knobs(30, 70, 1, 4, 6, 5);
    repeat (3000) do_cycle();

    // Mid-operation asynchronous reset
    set_knobs(100, 100, 1, 3, 0, 0);
    repeat (10) do_cycle();
    check_eq("pre_reset_head_valid", 32'(bus.instr_valid_op), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    do_reset();
    set_knobs(0, 100, 1, 1, 0, 0);
    repeat (10) do_cycle();
    check_eq("restart_first_req", 32'(first_req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
